id_stage: RTL and testbench
===========================

# id_stage

Decode stage of the RV32I five-stage pipeline, directly downstream of instruction fetch. Owns the IF/ID pipeline register, the 32×32 integer register file with write-back bypass, the immediate/control decoder, load-use hazard detection, and the ID/EX pipeline register. Applies the branch flush that fetch requires when `isBranch_E`=1.

## Interface
- `NOP_INSN`, default 32'h0000_0013, instruction word loaded into IF/ID on reset/flush (addi x0,x0,0)
- `CLK` in 1, clock
- `RST` in 1, reset, asynchronous, active-high
- `PC_IF` in 32, fetch PC
- `PC4_IF` in 32, fetch PC+4
- `IDATA_IF` in 32, fetched instruction
- `isBranch_E` in 1, taken branch/jump in EX; flushes IF/ID and ID/EX
- `WE_W` in 1, write-back enable
- `RD_W` in 5, write-back destination
- `WDATA_W` in 32, write-back data
- `STALL_D` out 1, load-use stall; fetch holds `PC_IF` while high
- `VALID_E` out 1, ID/EX holds a real instruction
- `PC_E`, `PC4_E` out 32 each
- `RS1DATA_E`, `RS2DATA_E` out 32 each, register operands
- `IMM_E` out 32, sign-extended immediate
- `RS1_E`, `RS2_E`, `RD_E` out 5 each
- `OPCODE_E` out 7, `FUNCT3_E` out 3, `FUNCT7B5_E` out 1 (instr bit 30)
- `REGWE_E`, `isLoad_E`, `isStore_E` out 1 each

## Operation
- IF/ID register (`PC_D`, `PC4_D`, `IDATA_D`): priority RST > `isBranch_E` (clear PCs to 0, `IDATA_D`=`NOP_INSN`) > `STALL_D` (hold) > load from IF.
- Register file: x0 always reads 0. Write at posedge when `WE_W` && `RD_W`≠0. Read bypass: when `WE_W` && `RD_W`≠0 && `RD_W`==rs, read returns `WDATA_W`. RST clears all registers to 0.
- Immediates, by opcode: I (LOAD 0000011, OP-IMM 0010011, JALR 1100111), S (0100011), B (1100011, bit0=0), U (LUI 0110111, AUIPC 0010111, low 12 bits 0), J (JAL 1101111, bit0=0). All others: IMM=0.
- `REGWE`: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP (0110011), and only when rd≠0. Unknown opcode: all control 0, `VALID`=0.
- rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP. rs2 used by BRANCH, STORE, OP.
- `STALL_D` (combinational) = `isLoad_E` && `RD_E`≠0 && ((rs1 used && rs1==`RD_E`) || (rs2 used && rs2==`RD_E`)) && !`isBranch_E`.
- ID/EX register: priority RST > `isBranch_E` (bubble) > `STALL_D` (bubble) > load decoded values. Bubble = every ID/EX output 0.

## Timing
- Reset: every output 0; `STALL_D`=0; IF/ID holds `NOP_INSN`.
- Latency: IF inputs to ID/EX outputs = 2 clock edges. Decode, bypass, and `STALL_D` are combinational from `IDATA_D` and current ID/EX state.
- Load-use: `STALL_D` high for exactly one cycle, then the dependent instruction issues with `VALID_E`=1.
- Flush with a simultaneous stall: flush wins, `STALL_D`=0, both stages bubble/NOP next edge.
- Write-back to a register read in the same cycle: the new value is captured into ID/EX at that edge.
- RST mid-stream: immediate asynchronous clear of both pipeline registers and the register file.

## Test plan
- Reset: assert RST -> `IDATA_D`=0x00000013, `VALID_E`=0, all `_E` outputs 0, `STALL_D`=0.
- `IDATA_IF`=0x00500093 (addi x1,x0,5), `PC_IF`=0x10 -> after 2 edges: `VALID_E`=1, `RD_E`=1, `IMM_E`=5, `REGWE_E`=1, `PC_E`=0x10, `PC4_E`=0x14.
- Bypass: `WE_W`=1, `RD_W`=3, `WDATA_W`=0xDEADBEEF while ID holds 0x00018233 (add x4,x3,x0) -> `RS1DATA_E`=0xDEADBEEF. Write to x0 with 0x1234 -> later reads of x0 = 0.
- Load-use: 0x0000A283 (lw x5,0(x1)) then 0x00528333 (add x6,x5,x5) -> `STALL_D`=1 for one cycle, one bubble (`VALID_E`=0), then add with `RD_E`=6, `RS1_E`=`RS2_E`=5.
- Flush: `isBranch_E`=1 during the load-use stall cycle -> `STALL_D`=0; next edge `IDATA_D`=0x13, `VALID_E`=0.
- Immediates: 0xFE000EE3 (beq x0,x0,-4) -> `IMM_E`=0xFFFFFFFC, `REGWE_E`=0. 0x123450B7 (lui x1) -> `IMM_E`=0x12345000.

Source files
------------

// File: rtl/id_stage_if.sv
// Signal bundle between fetch/write-back and the decode stage, and from decode into EX.
// The slave side is the decode stage; the master side is the surrounding pipeline.
interface id_stage_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  logic [XLEN-1:0] PC_IF;
  logic [XLEN-1:0] PC4_IF;
  logic [XLEN-1:0] IDATA_IF;
  logic            isBranch_E;
  logic            WE_W;
  logic [RW-1:0]   RD_W;
  logic [XLEN-1:0] WDATA_W;

  logic            STALL_D;
  logic [XLEN-1:0] IDATA_D;
  logic            VALID_E;
  logic [XLEN-1:0] PC_E;
  logic [XLEN-1:0] PC4_E;
  logic [XLEN-1:0] RS1DATA_E;
  logic [XLEN-1:0] RS2DATA_E;
  logic [XLEN-1:0] IMM_E;
  logic [RW-1:0]   RS1_E;
  logic [RW-1:0]   RS2_E;
  logic [RW-1:0]   RD_E;
  logic [6:0]      OPCODE_E;
  logic [2:0]      FUNCT3_E;
  logic            FUNCT7B5_E;
  logic            REGWE_E;
  logic            isLoad_E;
  logic            isStore_E;

  modport master (
    output PC_IF, PC4_IF, IDATA_IF, isBranch_E, WE_W, RD_W, WDATA_W,
    input  STALL_D, IDATA_D, VALID_E, PC_E, PC4_E, RS1DATA_E, RS2DATA_E, IMM_E,
           RS1_E, RS2_E, RD_E, OPCODE_E, FUNCT3_E, FUNCT7B5_E, REGWE_E, isLoad_E, isStore_E
  );

  modport slave (
    input  PC_IF, PC4_IF, IDATA_IF, isBranch_E, WE_W, RD_W, WDATA_W,
    output STALL_D, IDATA_D, VALID_E, PC_E, PC4_E, RS1DATA_E, RS2DATA_E, IMM_E,
           RS1_E, RS2_E, RD_E, OPCODE_E, FUNCT3_E, FUNCT7B5_E, REGWE_E, isLoad_E, isStore_E
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register, bypassed register file, immediate/control
// decode, load-use hazard detection and the ID/EX register.
module id_stage #(
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input logic       CLK,
  input logic       RST,
  id_stage_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned NREG = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            regwe;
    logic            is_load;
    logic            is_store;
  } ex_t;

  logic [XLEN-1:0] pc_d, pc4_d, idata_d;
  logic [XLEN-1:0] regs [NREG];
  logic [RW-1:0]   rs1, rs2, rd;
  logic [6:0]      opcode;
  logic [XLEN-1:0] rs1_data, rs2_data, imm;
  logic            valid, regwe, is_load, is_store, rs1_used, rs2_used;
  logic            stall_c;
  ex_t             ex_q, ex_next;

  assign opcode = idata_d[6:0];
  assign rd     = idata_d[11:7];
  assign rs1    = idata_d[19:15];
  assign rs2    = idata_d[24:20];

  // IF/ID register: flush to NOP beats stall-hold beats load
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_d    <= '0;
      pc4_d   <= '0;
      idata_d <= NOP_INSN;
    end else if (bus.isBranch_E) begin
      pc_d    <= '0;
      pc4_d   <= '0;
      idata_d <= NOP_INSN;
    end else if (!stall_c) begin
      pc_d    <= bus.PC_IF;
      pc4_d   <= bus.PC4_IF;
      idata_d <= bus.IDATA_IF;
    end
  end

  // Register file; x0 is never written so it stays zero after reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (bus.WE_W && (bus.RD_W != '0)) begin
      regs[bus.RD_W] <= bus.WDATA_W;
    end
  end

  // Reads see a same-cycle write-back so the value lands in ID/EX at this edge
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1 != '0) rs1_data = (bus.WE_W && bus.RD_W == rs1) ? bus.WDATA_W : regs[rs1];
    if (rs2 != '0) rs2_data = (bus.WE_W && bus.RD_W == rs2) ? bus.WDATA_W : regs[rs2];
  end

  // Immediate and control decode
  always_comb begin
    imm      = '0;
    valid    = 1'b0;
    regwe    = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    unique case (opcode)
      OP_LOAD: begin
        imm = {{20{idata_d[31]}}, idata_d[31:20]};
        valid = 1'b1; regwe = (rd != '0); is_load = 1'b1; rs1_used = 1'b1;
      end
      OP_IMM: begin
        imm = {{20{idata_d[31]}}, idata_d[31:20]};
        valid = 1'b1; regwe = (rd != '0); rs1_used = 1'b1;
      end
      OP_JALR: begin
        imm = {{20{idata_d[31]}}, idata_d[31:20]};
        valid = 1'b1; regwe = (rd != '0); rs1_used = 1'b1;
      end
      OP_STORE: begin
        imm = {{20{idata_d[31]}}, idata_d[31:25], idata_d[11:7]};
        valid = 1'b1; is_store = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OP_BRANCH: begin
        imm = {{19{idata_d[31]}}, idata_d[31], idata_d[7], idata_d[30:25], idata_d[11:8], 1'b0};
        valid = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm = {idata_d[31:12], 12'b0};
        valid = 1'b1; regwe = (rd != '0);
      end
      OP_JAL: begin
        imm = {{11{idata_d[31]}}, idata_d[31], idata_d[19:12], idata_d[20], idata_d[30:21], 1'b0};
        valid = 1'b1; regwe = (rd != '0);
      end
      OP_OP: begin
        valid = 1'b1; regwe = (rd != '0); rs1_used = 1'b1; rs2_used = 1'b1;
      end
      default: ;
    endcase
  end

  // Load-use hazard against the instruction now in EX; a flush cancels it
  assign stall_c = ex_q.is_load && (ex_q.rd != '0) &&
                   ((rs1_used && rs1 == ex_q.rd) || (rs2_used && rs2 == ex_q.rd)) &&
                   !bus.isBranch_E;

  always_comb begin
    ex_next          = '0;
    ex_next.valid    = valid;
    ex_next.pc       = pc_d;
    ex_next.pc4      = pc4_d;
    ex_next.rs1_data = rs1_data;
    ex_next.rs2_data = rs2_data;
    ex_next.imm      = imm;
    ex_next.rs1      = rs1;
    ex_next.rs2      = rs2;
    ex_next.rd       = rd;
    ex_next.opcode   = opcode;
    ex_next.funct3   = idata_d[14:12];
    ex_next.funct7b5 = idata_d[30];
    ex_next.regwe    = regwe;
    ex_next.is_load  = is_load;
    ex_next.is_store = is_store;
  end

  // ID/EX register: flush or stall inserts an all-zero bubble
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                            ex_q <= '0;
    else if (bus.isBranch_E || stall_c) ex_q <= '0;
    else                                ex_q <= ex_next;
  end

  assign bus.STALL_D    = stall_c;
  assign bus.IDATA_D    = idata_d;
  assign bus.VALID_E    = ex_q.valid;
  assign bus.PC_E       = ex_q.pc;
  assign bus.PC4_E      = ex_q.pc4;
  assign bus.RS1DATA_E  = ex_q.rs1_data;
  assign bus.RS2DATA_E  = ex_q.rs2_data;
  assign bus.IMM_E      = ex_q.imm;
  assign bus.RS1_E      = ex_q.rs1;
  assign bus.RS2_E      = ex_q.rs2;
  assign bus.RD_E       = ex_q.rd;
  assign bus.OPCODE_E   = ex_q.opcode;
  assign bus.FUNCT3_E   = ex_q.funct3;
  assign bus.FUNCT7B5_E = ex_q.funct7b5;
  assign bus.REGWE_E    = ex_q.regwe;
  assign bus.isLoad_E   = ex_q.is_load;
  assign bus.isStore_E  = ex_q.is_store;
endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage: reset, decode, bypass, load-use stall,
// flush and immediate formats with hand-computed expectations.
module tb_id_stage;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADDI_X1  = 32'h0050_0093;
  localparam logic [31:0] ADD_X4X3 = 32'h0001_8233;
  localparam logic [31:0] ADD_X4X0 = 32'h0000_0233;
  localparam logic [31:0] LW_X5    = 32'h0000_A283;
  localparam logic [31:0] ADD_X6X5 = 32'h0052_8333;
  localparam logic [31:0] BEQ_M4   = 32'hFE00_0EE3;
  localparam logic [31:0] LUI_X1   = 32'h1234_50B7;
  localparam logic [31:0] SW_X5    = 32'h0050_A423;
  localparam logic [31:0] BAD_OP   = 32'h0000_007F;
  localparam logic [31:0] ADD_X8X7 = 32'h0003_8433;

  logic CLK = 1'b0;
  logic RST;
  int   errors = 0;
  int   checks = 0;

  id_stage_if bus ();

  id_stage #(.NOP_INSN(NOP)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.PC_IF = '0; bus.PC4_IF = '0; bus.IDATA_IF = NOP;
    bus.isBranch_E = 1'b0; bus.WE_W = 1'b0; bus.RD_W = '0; bus.WDATA_W = '0;
    #12;
    checks++; if (bus.IDATA_D !== NOP) begin errors++; $display("FAIL reset_idata got=%h exp=%h", bus.IDATA_D, NOP); end
    checks++; if (bus.VALID_E !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.VALID_E); end
    checks++; if (bus.STALL_D !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.STALL_D); end
    checks++; if ({bus.PC_E, bus.PC4_E, bus.IMM_E, bus.RS1DATA_E, bus.RS2DATA_E} !== '0)
      begin errors++; $display("FAIL reset_data got nonzero pc=%h imm=%h", bus.PC_E, bus.IMM_E); end
    checks++; if ({bus.RS1_E, bus.RS2_E, bus.RD_E, bus.OPCODE_E, bus.FUNCT3_E, bus.FUNCT7B5_E,
                   bus.REGWE_E, bus.isLoad_E, bus.isStore_E} !== '0)
      begin errors++; $display("FAIL reset_ctrl got nonzero rd=%h op=%h", bus.RD_E, bus.OPCODE_E); end
    RST = 1'b0;
  endtask

  task automatic test_addi();
    bus.IDATA_IF = ADDI_X1; bus.PC_IF = 32'h10; bus.PC4_IF = 32'h14;
    tick();
    checks++; if (bus.IDATA_D !== ADDI_X1) begin errors++; $display("FAIL addi_ifid got=%h exp=%h", bus.IDATA_D, ADDI_X1); end
    bus.IDATA_IF = NOP; bus.PC_IF = '0; bus.PC4_IF = '0;
    tick();
    checks++; if (bus.VALID_E !== 1'b1) begin errors++; $display("FAIL addi_valid got=%b exp=1", bus.VALID_E); end
    checks++; if (bus.RD_E !== 5'd1) begin errors++; $display("FAIL addi_rd got=%0d exp=1", bus.RD_E); end
    checks++; if (bus.IMM_E !== 32'd5) begin errors++; $display("FAIL addi_imm got=%h exp=5", bus.IMM_E); end
    checks++; if (bus.REGWE_E !== 1'b1) begin errors++; $display("FAIL addi_regwe got=%b exp=1", bus.REGWE_E); end
    checks++; if (bus.PC_E !== 32'h10 || bus.PC4_E !== 32'h14)
      begin errors++; $display("FAIL addi_pc got=%h/%h exp=10/14", bus.PC_E, bus.PC4_E); end
    checks++; if (bus.OPCODE_E !== 7'h13) begin errors++; $display("FAIL addi_opcode got=%h exp=13", bus.OPCODE_E); end
  endtask

  task automatic test_bypass();
    bus.IDATA_IF = ADD_X4X3;
    tick();
    bus.IDATA_IF = NOP; bus.WE_W = 1'b1; bus.RD_W = 5'd3; bus.WDATA_W = 32'hDEADBEEF;
    tick();
    bus.WE_W = 1'b0;
    checks++; if (bus.RS1DATA_E !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rs1 got=%h exp=deadbeef", bus.RS1DATA_E); end
    checks++; if (bus.RS2DATA_E !== 32'h0 || bus.RD_E !== 5'd4)
      begin errors++; $display("FAIL bypass_rs2rd got=%h/%0d exp=0/4", bus.RS2DATA_E, bus.RD_E); end
    bus.IDATA_IF = ADD_X4X3;
    tick();
    bus.IDATA_IF = NOP;
    tick();
    checks++; if (bus.RS1DATA_E !== 32'hDEADBEEF) begin errors++; $display("FAIL regfile_x3 got=%h exp=deadbeef", bus.RS1DATA_E); end
    bus.IDATA_IF = ADD_X4X0;
    tick();
    bus.IDATA_IF = NOP; bus.WE_W = 1'b1; bus.RD_W = 5'd0; bus.WDATA_W = 32'h1234;
    tick();
    bus.WE_W = 1'b0;
    checks++; if (bus.RS1DATA_E !== 32'h0) begin errors++; $display("FAIL x0_bypass got=%h exp=0", bus.RS1DATA_E); end
    bus.IDATA_IF = ADD_X4X0;
    tick();
    bus.IDATA_IF = NOP;
    tick();
    checks++; if (bus.RS1DATA_E !== 32'h0 || bus.RS2DATA_E !== 32'h0)
      begin errors++; $display("FAIL x0_read got=%h/%h exp=0/0", bus.RS1DATA_E, bus.RS2DATA_E); end
  endtask

  task automatic test_load_use();
    bus.IDATA_IF = LW_X5; bus.PC_IF = 32'h40; bus.PC4_IF = 32'h44;
    tick();
    bus.IDATA_IF = ADD_X6X5; bus.PC_IF = 32'h44; bus.PC4_IF = 32'h48;
    tick();
    checks++; if (bus.STALL_D !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", bus.STALL_D); end
    checks++; if (bus.isLoad_E !== 1'b1 || bus.RD_E !== 5'd5)
      begin errors++; $display("FAIL lu_load got=%b/%0d exp=1/5", bus.isLoad_E, bus.RD_E); end
    bus.IDATA_IF = NOP; bus.PC_IF = '0; bus.PC4_IF = '0;
    tick();
    checks++; if (bus.VALID_E !== 1'b0 || bus.STALL_D !== 1'b0)
      begin errors++; $display("FAIL lu_bubble got=valid %b stall %b exp=0 0", bus.VALID_E, bus.STALL_D); end
    checks++; if (bus.IDATA_D !== ADD_X6X5) begin errors++; $display("FAIL lu_hold got=%h exp=%h", bus.IDATA_D, ADD_X6X5); end
    tick();
    checks++; if (bus.VALID_E !== 1'b1 || bus.RD_E !== 5'd6)
      begin errors++; $display("FAIL lu_issue got=valid %b rd %0d exp=1 6", bus.VALID_E, bus.RD_E); end
    checks++; if (bus.RS1_E !== 5'd5 || bus.RS2_E !== 5'd5)
      begin errors++; $display("FAIL lu_rs got=%0d/%0d exp=5/5", bus.RS1_E, bus.RS2_E); end
    checks++; if (bus.PC_E !== 32'h44) begin errors++; $display("FAIL lu_pc got=%h exp=44", bus.PC_E); end
  endtask

  task automatic test_flush();
    bus.IDATA_IF = LW_X5; bus.PC_IF = 32'h80;
    tick();
    bus.IDATA_IF = ADD_X6X5; bus.PC_IF = 32'h84;
    tick();
    checks++; if (bus.STALL_D !== 1'b1) begin errors++; $display("FAIL fl_prestall got=%b exp=1", bus.STALL_D); end
    bus.isBranch_E = 1'b1;
    #1;
    checks++; if (bus.STALL_D !== 1'b0) begin errors++; $display("FAIL fl_stall got=%b exp=0", bus.STALL_D); end
    bus.IDATA_IF = NOP; bus.PC_IF = '0;
    tick();
    bus.isBranch_E = 1'b0;
    checks++; if (bus.IDATA_D !== NOP) begin errors++; $display("FAIL fl_idata got=%h exp=13", bus.IDATA_D); end
    checks++; if (bus.VALID_E !== 1'b0 || bus.PC_E !== 32'h0)
      begin errors++; $display("FAIL fl_bubble got=valid %b pc %h exp=0 0", bus.VALID_E, bus.PC_E); end
    tick();
  endtask

  task automatic test_back_to_back_imm();
    bus.IDATA_IF = BEQ_M4;
    tick();
    bus.IDATA_IF = LUI_X1;
    tick();
    checks++; if (bus.IMM_E !== 32'hFFFFFFFC) begin errors++; $display("FAIL beq_imm got=%h exp=fffffffc", bus.IMM_E); end
    checks++; if (bus.REGWE_E !== 1'b0 || bus.VALID_E !== 1'b1)
      begin errors++; $display("FAIL beq_ctrl got=regwe %b valid %b exp=0 1", bus.REGWE_E, bus.VALID_E); end
    bus.IDATA_IF = SW_X5;
    tick();
    checks++; if (bus.IMM_E !== 32'h12345000) begin errors++; $display("FAIL lui_imm got=%h exp=12345000", bus.IMM_E); end
    checks++; if (bus.REGWE_E !== 1'b1 || bus.RD_E !== 5'd1)
      begin errors++; $display("FAIL lui_ctrl got=regwe %b rd %0d exp=1 1", bus.REGWE_E, bus.RD_E); end
    bus.IDATA_IF = BAD_OP;
    tick();
    checks++; if (bus.IMM_E !== 32'd8 || bus.isStore_E !== 1'b1)
      begin errors++; $display("FAIL sw_imm got=imm %h store %b exp=8 1", bus.IMM_E, bus.isStore_E); end
    checks++; if (bus.REGWE_E !== 1'b0 || bus.RS2_E !== 5'd5 || bus.FUNCT3_E !== 3'd2)
      begin errors++; $display("FAIL sw_ctrl got=regwe %b rs2 %0d f3 %0d exp=0 5 2", bus.REGWE_E, bus.RS2_E, bus.FUNCT3_E); end
    bus.IDATA_IF = NOP;
    tick();
    checks++; if (bus.VALID_E !== 1'b0 || bus.IMM_E !== 32'h0 || bus.REGWE_E !== 1'b0)
      begin errors++; $display("FAIL badop got=valid %b imm %h regwe %b exp=0 0 0", bus.VALID_E, bus.IMM_E, bus.REGWE_E); end
  endtask

  task automatic test_rst_mid();
    bus.WE_W = 1'b1; bus.RD_W = 5'd7; bus.WDATA_W = 32'hCAFEF00D;
    tick();
    bus.WE_W = 1'b0;
    bus.IDATA_IF = ADD_X8X7;
    tick();
    bus.IDATA_IF = NOP;
    tick();
    checks++; if (bus.RS1DATA_E !== 32'hCAFEF00D) begin errors++; $display("FAIL pre_rst_x7 got=%h exp=cafef00d", bus.RS1DATA_E); end
    bus.IDATA_IF = ADD_X8X7; bus.PC_IF = 32'h100;
    tick();
    #3;
    RST = 1'b1;
    #1;
    checks++; if (bus.VALID_E !== 1'b0 || bus.RS1DATA_E !== 32'h0 || bus.PC_E !== 32'h0)
      begin errors++; $display("FAIL mid_rst_ex got=valid %b rs1 %h exp=0 0", bus.VALID_E, bus.RS1DATA_E); end
    checks++; if (bus.IDATA_D !== NOP) begin errors++; $display("FAIL mid_rst_ifid got=%h exp=13", bus.IDATA_D); end
    #2;
    RST = 1'b0;
    bus.PC_IF = '0;
    tick();
    bus.IDATA_IF = NOP;
    tick();
    checks++; if (bus.RS1DATA_E !== 32'h0 || bus.RD_E !== 5'd8)
      begin errors++; $display("FAIL post_rst_x7 got=%h rd %0d exp=0 8", bus.RS1DATA_E, bus.RD_E); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_bypass();
    test_load_use();
    test_flush();
    test_back_to_back_imm();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
